// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM encoding, divider/width helpers and the parity function.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Rounded clocks-per-bit so that odd ratios land on the nearest integer.
    function automatic int calc_div(input int clk_freq_hz, input int baud);
        return (clk_freq_hz + (baud / 2)) / baud;
    endfunction

    function automatic int calc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..DIV-1 while run is high and strobes bit_tick on the last count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int              CW   = calc_cnt_w(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_baud_gen: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero when idle or cleared, wraps after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: NBYTES frames of start/8 data/[parity]/stop sent back to back.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after data bit 7.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int NBYTES      = 2,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_start,
    input  logic [8*NBYTES-1:0]   tx_data,
    output logic                  TxD,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int              DIV        = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int              BW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0]   LAST_BYTE  = BW'(NBYTES - 1);
    localparam logic            STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    if ((NBYTES < 1) || (NBYTES > 16)) begin : g_nbytes_chk
        $error("uart_tx_frame: NBYTES must be 1..16");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_chk
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_par_chk
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    uart_state_e                            state_q, state_d;
    logic [NBYTES-1:0][DATA_BITS-1:0]       shadow_q, shadow_d;
    logic [BW-1:0]                          byte_q, byte_d;
    logic [2:0]                             bit_q, bit_d;
    logic                                   stop_q, stop_d;
    logic                                   txd_q, txd_d;
    logic                                   busy_q, busy_d;
    logic                                   done_q, done_d;
    logic                                   bit_tick_s;
    logic                                   accept_s;
    logic [DATA_BITS-1:0]                   cur_byte_s;

    assign accept_s   = (state_q == ST_IDLE) && tx_start;
    assign cur_byte_s = shadow_q[byte_q];

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept_s),
        .run      (state_q != ST_IDLE),
        .bit_tick (bit_tick_s)
    );

    // Next-state logic; line level is taken from the current state so TxD trails the FSM by one clock.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        txd_d    = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_d = '0;
                bit_d  = 3'd0;
                stop_d = 1'b0;
                if (tx_start) begin
                    state_d  = ST_START;
                    shadow_d = tx_data;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_tick_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                txd_d = cur_byte_s[bit_q];
                if (bit_tick_s && (bit_q == 3'd7)) begin
                    bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else if (bit_tick_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    bit_d = bit_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_d = calc_parity(cur_byte_s, (PARITY_ODD != 0));
                if (bit_tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_tick_s && (stop_q == STOP_LAST)) begin
                    stop_d = 1'b0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + BW'(1);
                        state_d = ST_START;
                    end
                end else if (bit_tick_s) begin
                    stop_d = stop_q + 1'b1;
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            byte_q   <= '0;
            bit_q    <= 3'd0;
            stop_q   <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign TxD     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: several parameterisations sharing one clock and reset.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_q;
    logic [15:0]  data_q;
    logic [2:0]   sel;
    logic [4:0]   start_v;
    logic [4:0]   txd_w, busy_w, done_w;
    logic         txd_m, busy_m, done_m;
    logic [299:0] txd_log, busy_log, done_log;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    assign start_v = start_q ? (5'b00001 << sel) : 5'b00000;
    assign txd_m   = txd_w[sel];
    assign busy_m  = busy_w[sel];
    assign done_m  = done_w[sel];

    uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .NBYTES(2), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .reset_n(reset_n), .tx_start(start_v[0]), .tx_data(data_q),
        .TxD(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .NBYTES(1), .STOP_BITS(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset_n(reset_n), .tx_start(start_v[1]), .tx_data(data_q[7:0]),
        .TxD(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .NBYTES(1), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset_n(reset_n), .tx_start(start_v[2]), .tx_data(data_q[7:0]),
        .TxD(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .NBYTES(2), .STOP_BITS(2), .PARITY_ODD(0)) u3 (
        .clk(clk), .reset_n(reset_n), .tx_start(start_v[3]), .tx_data(data_q),
        .TxD(txd_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
    uart_tx_frame u4 (
        .clk(clk), .reset_n(reset_n), .tx_start(start_v[4]), .tx_data(data_q),
        .TxD(txd_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

    // Expected line per sample: sample 0 is idle, then each frame bit (first bit in the MSB of bits) lasts div samples.
    function automatic logic [299:0] exp_wave(input logic [31:0] bits, input int nbits, input int div);
        logic [299:0] w;
        w = '1;
        for (int i = 1; i <= nbits * div; i++) begin
            w[i] = bits[nbits - 1 - ((i - 1) / div)];
        end
        return w;
    endfunction

    function automatic logic [299:0] exp_busy(input int total);
        logic [299:0] w;
        w = '0;
        for (int i = 0; i < total; i++) begin
            w[i] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [299:0] exp_done(input int total);
        logic [299:0] w;
        w        = '0;
        w[total] = 1'b1;
        return w;
    endfunction

    task automatic launch(input logic [2:0] s, input logic [15:0] d);
        @(negedge clk);
        sel     = s;
        data_q  = d;
        start_q = 1'b1;
    endtask

    // Samples n cycles after acceptance; optionally pulses a stray start with all-ones data at sample inj.
    task automatic record(input int n, input int inj);
        txd_log  = '1;
        busy_log = '0;
        done_log = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txd_log[i]  = txd_m;
            busy_log[i] = busy_m;
            done_log[i] = done_m;
            if (i == inj) begin
                start_q = 1'b1;
                data_q  = 16'hFFFF;
            end else begin
                start_q = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start_q = 1'b0;
        data_q  = 16'h0000;
        sel     = 3'd0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            checks++; if (txd_w[j] !== 1'b1)  begin errors++; $display("FAIL reset_txd[%0d]: got %b expected 1", j, txd_w[j]); end
            checks++; if (busy_w[j] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", j, busy_w[j]); end
            checks++; if (done_w[j] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", j, done_w[j]); end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_framing(input string name, input int inj);
        logic [31:0] e;
        int nb;
`ifdef UART_TX_PARITY_EN
        e = 32'b00101101001_01010010101;
`else
        e = 32'b0010110101_0101001011;
`endif
        nb = 20 + 2 * P;
        launch(3'd0, 16'hA55A);
        record(nb * 10 + 6, inj);
        checks++; if (txd_log !== exp_wave(e, nb, 10)) begin errors++; $display("FAIL %s_txd: got %h expected %h", name, txd_log, exp_wave(e, nb, 10)); end
        checks++; if (busy_log !== exp_busy(nb * 10)) begin errors++; $display("FAIL %s_busy: got %h expected %h", name, busy_log, exp_busy(nb * 10)); end
        checks++; if (done_log !== exp_done(nb * 10)) begin errors++; $display("FAIL %s_done: got %h expected %h", name, done_log, exp_done(nb * 10)); end
    endtask

    task automatic test_parity;
        logic [31:0] e0, e1;
        int nb;
`ifdef UART_TX_PARITY_EN
        e0 = 32'b01110000011;
        e1 = 32'b01110000001;
`else
        e0 = 32'b0111000001;
        e1 = 32'b0111000001;
`endif
        nb = 10 + P;
        launch(3'd1, 16'h0007);
        record(nb * 10 + 6, -1);
        checks++; if (txd_log !== exp_wave(e0, nb, 10)) begin errors++; $display("FAIL parity_even_txd: got %h expected %h", txd_log, exp_wave(e0, nb, 10)); end
        checks++; if (busy_log !== exp_busy(nb * 10)) begin errors++; $display("FAIL parity_even_busy: got %h expected %h", busy_log, exp_busy(nb * 10)); end
        checks++; if (done_log !== exp_done(nb * 10)) begin errors++; $display("FAIL parity_even_done: got %h expected %h", done_log, exp_done(nb * 10)); end
        launch(3'd2, 16'h0007);
        record(nb * 10 + 6, -1);
        checks++; if (txd_log !== exp_wave(e1, nb, 10)) begin errors++; $display("FAIL parity_odd_txd: got %h expected %h", txd_log, exp_wave(e1, nb, 10)); end
        checks++; if (busy_log !== exp_busy(nb * 10)) begin errors++; $display("FAIL parity_odd_busy: got %h expected %h", busy_log, exp_busy(nb * 10)); end
        checks++; if (done_log !== exp_done(nb * 10)) begin errors++; $display("FAIL parity_odd_done: got %h expected %h", done_log, exp_done(nb * 10)); end
    endtask

    task automatic test_two_stop;
        logic [31:0] e;
        int nb;
`ifdef UART_TX_PARITY_EN
        e = 32'b001011010011_010100101011;
`else
        e = 32'b00101101011_01010010111;
`endif
        nb = 22 + 2 * P;
        launch(3'd3, 16'hA55A);
        record(nb * 10 + 6, -1);
        checks++; if (txd_log !== exp_wave(e, nb, 10)) begin errors++; $display("FAIL two_stop_txd: got %h expected %h", txd_log, exp_wave(e, nb, 10)); end
        checks++; if (busy_log !== exp_busy(nb * 10)) begin errors++; $display("FAIL two_stop_busy: got %h expected %h", busy_log, exp_busy(nb * 10)); end
        checks++; if (done_log !== exp_done(nb * 10)) begin errors++; $display("FAIL two_stop_done: got %h expected %h", done_log, exp_done(nb * 10)); end
    endtask

    task automatic test_async_reset;
        logic [31:0] e;
        int nb;
`ifdef UART_TX_PARITY_EN
        e = 32'b00010110011_00100100001;
`else
        e = 32'b0001011001_0010010001;
`endif
        nb = 20 + 2 * P;
        launch(3'd0, 16'hA55A);
        @(negedge clk);
        start_q = 1'b0;
        repeat (36) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (txd_m !== 1'b1)  begin errors++; $display("FAIL areset_txd: got %b expected 1", txd_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done_m); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL areset_no_done: got %b expected 0", done_m); end
        launch(3'd0, 16'h1234);
        record(nb * 10 + 6, -1);
        checks++; if (txd_log !== exp_wave(e, nb, 10)) begin errors++; $display("FAIL areset_frame_txd: got %h expected %h", txd_log, exp_wave(e, nb, 10)); end
        checks++; if (busy_log !== exp_busy(nb * 10)) begin errors++; $display("FAIL areset_frame_busy: got %h expected %h", busy_log, exp_busy(nb * 10)); end
        checks++; if (done_log !== exp_done(nb * 10)) begin errors++; $display("FAIL areset_frame_done: got %h expected %h", done_log, exp_done(nb * 10)); end
    endtask

    task automatic test_default_div;
        int  low_cnt;
        logic seen_high;
        low_cnt   = 0;
        seen_high = 1'b0;
        launch(3'd4, 16'h00FF);
        @(negedge clk);
        start_q = 1'b0;
        checks++; if (txd_m !== 1'b1) begin errors++; $display("FAIL default_idle_txd: got %b expected 1", txd_m); end
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (txd_m === 1'b0) begin
                low_cnt++;
            end else begin
                seen_high = 1'b1;
                break;
            end
        end
        checks++; if (!seen_high || (low_cnt != 10417)) begin errors++; $display("FAIL default_start_width: got %0d clocks (ended=%b) expected 10417", low_cnt, seen_high); end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_framing("framing", -1);
        test_framing("busy_reject", 50);
        test_parity();
        test_two_stop();
        test_async_reset();
        test_default_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
